// File: rtl/regfile_fwd_pkg.sv
// regfile_fwd_pkg
// Shared definitions for the forwarding register file: default widths,
// register bus types, the zero word and the read-port source selector.
// No ports; imported by the interface, the read-port mux and the top.

package regfile_fwd_pkg;

   localparam int DefDataW   = 16;
   localparam int DefDepth   = 8;
   localparam int DefNumRead = 2;
   localparam int DefCntW    = 16;

   // Address width for a given depth. A single-entry file still gets one
   // address bit so every port keeps a non-zero width.
   function automatic int addrWidth(input int depth);
      return (depth <= 2) ? 1 : $clog2(depth);
   endfunction

   localparam int DefAddrW = addrWidth(DefDepth);

   typedef logic [DefDataW-1:0] RegBus;
   typedef logic [DefAddrW-1:0] RegAddrBus;

   localparam RegBus ZeroWord = '0;

   // Where a read port takes its operand from, in priority order.
   typedef enum logic [2:0] {
      SrcOff,     // port disabled or address outside the file
      SrcZero,    // hardwired zero register
      SrcEx,      // EX-stage result (non-load)
      SrcMem,     // MEM-stage result
      SrcWb,      // write-back data in the same cycle
      SrcArray    // stored register value
   } FwdSrc;

endpackage

// File: rtl/regfile_fwd_if.sv
// regfile_fwd_if
// Bundles the register-file bus: write-back port, read ports, EX/MEM
// forwarding inputs and the load-use stall outputs.
// Modports:
//   master - pipeline side (drives write-back, reads, forwarding, clear)
//   slave  - register file (drives rData_o, stallReq_o, stallCnt_o)

interface regfile_fwd_if
   import regfile_fwd_pkg::*;
#(
   parameter int DATA_W   = DefDataW,
   parameter int ADDR_W   = DefAddrW,
   parameter int NUM_READ = DefNumRead,
   parameter int CNT_W    = DefCntW
) ();

   logic                       wEnable_i;
   logic [ADDR_W-1:0]          wAddr_i;
   logic [DATA_W-1:0]          wData_i;

   logic [NUM_READ-1:0]        rEnable_i;
   logic [NUM_READ*ADDR_W-1:0] rAddr_i;
   logic [NUM_READ*DATA_W-1:0] rData_o;

   logic                       exWReg_i;
   logic [ADDR_W-1:0]          exWRegAddr_i;
   logic [DATA_W-1:0]          exWData_i;
   logic                       exIsLoad_i;

   logic                       memWReg_i;
   logic [ADDR_W-1:0]          memWRegAddr_i;
   logic [DATA_W-1:0]          memWData_i;

   logic                       stallReq_o;
   logic [CNT_W-1:0]           stallCnt_o;
   logic                       stallCntClr_i;

   modport master (
      output wEnable_i, wAddr_i, wData_i,
      output rEnable_i, rAddr_i,
      output exWReg_i, exWRegAddr_i, exWData_i, exIsLoad_i,
      output memWReg_i, memWRegAddr_i, memWData_i,
      output stallCntClr_i,
      input  rData_o, stallReq_o, stallCnt_o
   );

   modport slave (
      input  wEnable_i, wAddr_i, wData_i,
      input  rEnable_i, rAddr_i,
      input  exWReg_i, exWRegAddr_i, exWData_i, exIsLoad_i,
      input  memWReg_i, memWRegAddr_i, memWData_i,
      input  stallCntClr_i,
      output rData_o, stallReq_o, stallCnt_o
   );

endinterface

// File: rtl/regfile_fwd_mux.sv
// regfile_fwd_mux
// One read port: picks the operand from EX, MEM, write-back or the array
// (youngest producer first) and flags a load-use hazard on that port.
// Ports:
//   rEnable/rAddr        - read request for this port
//   arrayData            - stored value of register rAddr
//   exWReg..exIsLoad     - EX-stage producer
//   memWReg..memWData    - MEM-stage producer
//   wEnable/wAddr/wData  - write-back happening this cycle
//   rData                - selected operand (0 when disabled)
//   hazard               - EX holds a load targeting rAddr

module regfile_fwd_mux
   import regfile_fwd_pkg::*;
#(
   parameter int DATA_W   = DefDataW,
   parameter int DEPTH    = DefDepth,
   parameter int ADDR_W   = addrWidth(DEPTH),
   parameter int ZERO_REG = 0
) (
   input  logic              rEnable,
   input  logic [ADDR_W-1:0] rAddr,
   input  logic [DATA_W-1:0] arrayData,
   input  logic              exWReg,
   input  logic [ADDR_W-1:0] exWRegAddr,
   input  logic [DATA_W-1:0] exWData,
   input  logic              exIsLoad,
   input  logic              memWReg,
   input  logic [ADDR_W-1:0] memWRegAddr,
   input  logic [DATA_W-1:0] memWData,
   input  logic              wEnable,
   input  logic [ADDR_W-1:0] wAddr,
   input  logic [DATA_W-1:0] wData,
   output logic [DATA_W-1:0] rData,
   output logic              hazard
);

   // One extra bit so DEPTH itself is representable for the range check.
   localparam logic [ADDR_W:0] DepthV = (ADDR_W+1)'(DEPTH);

   FwdSrc src;
   logic  inRange;
   logic  isZero;
   logic  exHit;

   always_comb begin
      src     = SrcArray;
      hazard  = 1'b0;
      inRange = ({1'b0, rAddr} < DepthV);
      isZero  = (ZERO_REG != 0) && (rAddr == '0);
      exHit   = exWReg && (exWRegAddr == rAddr);

      if (!rEnable || !inRange) begin
         src = SrcOff;
      end else if (isZero) begin
         src = SrcZero;
      end else begin
         // A load in EX has no data yet: raise the hazard and let the
         // operand fall through to older producers (it will be replayed).
         hazard = exHit && exIsLoad;
         if (exHit && !exIsLoad)
            src = SrcEx;
         else if (memWReg && (memWRegAddr == rAddr))
            src = SrcMem;
         else if (wEnable && (wAddr == rAddr))
            src = SrcWb;
         else
            src = SrcArray;
      end
   end

   always_comb begin
      rData = DATA_W'(ZeroWord);
      case (src)
         SrcEx:    rData = exWData;
         SrcMem:   rData = memWData;
         SrcWb:    rData = wData;
         SrcArray: rData = arrayData;
         default:  rData = DATA_W'(ZeroWord);
      endcase
   end

endmodule

// File: rtl/regfile_fwd.sv
// regfile_fwd
// General-purpose register file with NUM_READ forwarded read ports, one
// write-back port, load-use hazard detection and a saturating stall
// counter.
// Ports:
//   clk  - clock, all state changes on the rising edge
//   rst  - asynchronous active-low reset; clears array and counter and
//          forces rData_o / stallReq_o to 0 while low
//   bus  - regfile_fwd_if.slave: write-back, read ports, EX/MEM
//          forwarding, stallReq_o, stallCnt_o, stallCntClr_i

module regfile_fwd
   import regfile_fwd_pkg::*;
#(
   parameter int DATA_W   = DefDataW,
   parameter int DEPTH    = DefDepth,
   parameter int NUM_READ = DefNumRead,
   parameter int ZERO_REG = 0,
   parameter int CNT_W    = DefCntW
) (
   input  logic         clk,
   input  logic         rst,
   regfile_fwd_if.slave bus
);

   localparam int ADDR_W = addrWidth(DEPTH);
   localparam logic [ADDR_W:0] DepthV = (ADDR_W+1)'(DEPTH);

   logic [DATA_W-1:0]          regArray [DEPTH];
   logic [NUM_READ*DATA_W-1:0] muxData;
   logic [NUM_READ-1:0]        hazardVec;
   logic                       stallReq;
   logic                       wrAllowed;
   logic [CNT_W-1:0]           stallCntReg;
   logic [CNT_W-1:0]           stallCntNext;

   // ---------------------------------------------------------------
   // Write-back into the array
   // ---------------------------------------------------------------
   assign wrAllowed = bus.wEnable_i
                    && ({1'b0, bus.wAddr_i} < DepthV)
                    && !((ZERO_REG != 0) && (bus.wAddr_i == '0));

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < DEPTH; i++)
            regArray[i] <= '0;
      end else if (wrAllowed) begin
         regArray[bus.wAddr_i] <= bus.wData_i;
      end
   end

   // ---------------------------------------------------------------
   // Read ports
   // ---------------------------------------------------------------
   for (genvar gi = 0; gi < NUM_READ; gi++) begin : gRead
      logic [ADDR_W-1:0] portAddr;
      logic [DATA_W-1:0] arrayData;

      assign portAddr = bus.rAddr_i[gi*ADDR_W +: ADDR_W];
      // Out-of-range addresses are masked to 0 inside the mux.
      assign arrayData = regArray[portAddr];

      regfile_fwd_mux #(
         .DATA_W   (DATA_W),
         .DEPTH    (DEPTH),
         .ADDR_W   (ADDR_W),
         .ZERO_REG (ZERO_REG)
      ) uMux (
         .rEnable     (bus.rEnable_i[gi]),
         .rAddr       (portAddr),
         .arrayData   (arrayData),
         .exWReg      (bus.exWReg_i),
         .exWRegAddr  (bus.exWRegAddr_i),
         .exWData     (bus.exWData_i),
         .exIsLoad    (bus.exIsLoad_i),
         .memWReg     (bus.memWReg_i),
         .memWRegAddr (bus.memWRegAddr_i),
         .memWData    (bus.memWData_i),
         .wEnable     (bus.wEnable_i),
         .wAddr       (bus.wAddr_i),
         .wData       (bus.wData_i),
         .rData       (muxData[gi*DATA_W +: DATA_W]),
         .hazard      (hazardVec[gi])
      );
   end

   // Outputs are held at zero for as long as reset is asserted.
   assign bus.rData_o    = rst ? muxData : '0;
   assign stallReq       = rst && (|hazardVec);
   assign bus.stallReq_o = stallReq;

   // ---------------------------------------------------------------
   // Stall cycle counter: clear beats increment, saturates at all-ones
   // ---------------------------------------------------------------
   always_comb begin
      stallCntNext = stallCntReg;
      if (bus.stallCntClr_i)
         stallCntNext = '0;
      else if (stallReq && (stallCntReg != {CNT_W{1'b1}}))
         stallCntNext = stallCntReg + CNT_W'(1);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         stallCntReg <= '0;
      else
         stallCntReg <= stallCntNext;
   end

   assign bus.stallCnt_o = stallCntReg;

endmodule
